ram_arbiter: RTL and testbench

- Shares the single-port 4K x 8 frame RAM between two burst requesters: the ADC transfer writer (write bursts) and the com sender (read bursts).
- Each requester uses a 4-phase fs/fd handshake and supplies a burst base address and length, the same way the console programs ram_addr_init/ram_dlen.
- The arbiter grants one burst at a time with round-robin fairness, generates the RAM addresses and counts the words.

---
 rtl/ram_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port frame RAM between a burst writer
// and a burst reader, each using a 4-phase fs/fd request/done handshake.
module ram_arbiter #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs_wr,
    output logic          fd_wr,
    input  logic [AW-1:0] wr_addr_init,
    input  logic [AW-1:0] wr_dlen,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          fs_rd,
    output logic          fd_rd,
    input  logic [AW-1:0] rd_addr_init,
    input  logic [AW-1:0] rd_dlen,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_WORK  = 3'd1;
    localparam logic [2:0] S_WR_DONE  = 3'd2;
    localparam logic [2:0] S_RD_WORK  = 3'd3;
    localparam logic [2:0] S_RD_DRAIN = 3'd4;
    localparam logic [2:0] S_RD_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] dlen_q, dlen_d;
    logic          last_wr_q, last_wr_d;  // 1: writer held the most recent grant
    logic          rd_valid_q;
    logic          rd_issue;
    logic          last_word;

    assign last_word = (cnt_q == dlen_q - AW'(1));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        dlen_d    = dlen_q;
        last_wr_d = last_wr_q;
        wr_ready  = 1'b0;
        fd_wr     = 1'b0;
        fd_rd     = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        rd_issue  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On contention the side that did not win last time is served.
                if (fs_wr && (!fs_rd || !last_wr_q)) begin
                    base_d    = wr_addr_init;
                    dlen_d    = wr_dlen;
                    cnt_d     = '0;
                    last_wr_d = 1'b1;
                    state_d   = (wr_dlen == '0) ? S_WR_DONE : S_WR_WORK;
                end else if (fs_rd) begin
                    base_d    = rd_addr_init;
                    dlen_d    = rd_dlen;
                    cnt_d     = '0;
                    last_wr_d = 1'b0;
                    state_d   = (rd_dlen == '0) ? S_RD_DONE : S_RD_WORK;
                end
            end
            S_WR_WORK: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = base_q + cnt_q;
                    ram_din  = wr_data;
                    cnt_d    = cnt_q + AW'(1);
                    if (last_word) state_d = S_WR_DONE;
                end
            end
            S_WR_DONE: begin
                fd_wr = 1'b1;
                if (!fs_wr) state_d = S_IDLE;
            end
            S_RD_WORK: begin
                if (rd_ready) begin
                    ram_en   = 1'b1;
                    ram_addr = base_q + cnt_q;
                    rd_issue = 1'b1;
                    cnt_d    = cnt_q + AW'(1);
                    if (last_word) state_d = S_RD_DRAIN;
                end
            end
            S_RD_DRAIN: state_d = S_RD_DONE;
            S_RD_DONE: begin
                fd_rd = 1'b1;
                if (!fs_rd) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            dlen_q     <= '0;
            last_wr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            dlen_q     <= dlen_d;
            last_wr_q  <= last_wr_d;
            rd_valid_q <= rd_issue;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = ram_dout;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: burst-level reference model, bench-side
// RAM, directed scenarios with literal expectations, then randomized bursts.
module tb_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fs_wr = 1'b0, fs_rd = 1'b0;
    logic          fd_wr, fd_rd;
    logic [AW-1:0] wr_addr_init = '0, wr_dlen = '0;
    logic [AW-1:0] rd_addr_init = '0, rd_dlen = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0, wr_ready;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .fs_wr(fs_wr), .fd_wr(fd_wr), .wr_addr_init(wr_addr_init), .wr_dlen(wr_dlen),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .fs_rd(fs_rd), .fd_rd(fd_rd), .rd_addr_init(rd_addr_init), .rd_dlen(rd_dlen),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    // Bench-side single-port RAM with one cycle of read latency.
    bit [7:0] mem [4096];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: which burst is active, how many words it has moved, and
    // the RAM contents the bursts should have produced.
    typedef enum int {M_IDLE, M_WR, M_WR_END, M_RD, M_RD_TAIL, M_RD_END} mphase_t;
    mphase_t    m_ph = M_IDLE;
    int         m_base = 0, m_len = 0, m_done = 0;
    bit         m_last_wr = 1'b0;
    bit         m_rdv = 1'b0;
    bit [7:0]   shadow [4096];
    bit [7:0]   rdq [$];
    bit         wbeat, rissue;
    int         m_a;
    bit [7:0]   exp_d;

    int       acc_addr [$];
    bit       acc_we [$];
    int       acc_cyc [$];
    bit [7:0] rd_log [$];
    int       rd_cyc [$];
    int       fdrd_cyc [$];

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_busy", busy, 0);
            check("rst_fd_wr", fd_wr, 0);
            check("rst_fd_rd", fd_rd, 0);
            check("rst_wr_ready", wr_ready, 0);
            check("rst_ram_en", ram_en, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_din", ram_din, 0);
            check("rst_rd_valid", rd_valid, 0);
            m_ph = M_IDLE;
            m_done = 0;
            m_last_wr = 1'b0;
            m_rdv = 1'b0;
            rdq.delete();
        end else begin
            wbeat = (m_ph == M_WR) && wr_valid;
            rissue = (m_ph == M_RD) && rd_ready;
            m_a = (m_base + m_done) % 4096;
            check("busy", busy, m_ph != M_IDLE);
            check("wr_ready", wr_ready, m_ph == M_WR);
            check("fd_wr", fd_wr, m_ph == M_WR_END);
            check("fd_rd", fd_rd, m_ph == M_RD_END);
            check("ram_en", ram_en, wbeat || rissue);
            check("ram_we", ram_we, wbeat);
            if (wbeat || rissue) check("ram_addr", ram_addr, m_a);
            if (wbeat) check("ram_din", ram_din, wr_data);
            check("rd_valid", rd_valid, m_rdv);
            if (m_rdv && rd_valid && rdq.size() > 0) begin
                exp_d = rdq.pop_front();
                check("rd_data", rd_data, exp_d);
            end

            if (ram_en) begin
                acc_addr.push_back(int'(ram_addr));
                acc_we.push_back(ram_we);
                acc_cyc.push_back(cyc);
            end
            if (rd_valid) begin
                rd_log.push_back(rd_data);
                rd_cyc.push_back(cyc);
            end
            if (fd_rd) fdrd_cyc.push_back(cyc);

            m_rdv = rissue;
            case (m_ph)
                M_IDLE: begin
                    if (fs_wr && (!fs_rd || !m_last_wr)) begin
                        m_base = int'(wr_addr_init);
                        m_len = int'(wr_dlen);
                        m_done = 0;
                        m_last_wr = 1'b1;
                        m_ph = (m_len == 0) ? M_WR_END : M_WR;
                    end else if (fs_rd) begin
                        m_base = int'(rd_addr_init);
                        m_len = int'(rd_dlen);
                        m_done = 0;
                        m_last_wr = 1'b0;
                        m_ph = (m_len == 0) ? M_RD_END : M_RD;
                    end
                end
                M_WR: if (wbeat) begin
                    shadow[m_a] = wr_data;
                    m_done++;
                    if (m_done == m_len) m_ph = M_WR_END;
                end
                M_WR_END: if (!fs_wr) m_ph = M_IDLE;
                M_RD: if (rissue) begin
                    rdq.push_back(shadow[m_a]);
                    m_done++;
                    if (m_done == m_len) m_ph = M_RD_TAIL;
                end
                M_RD_TAIL: m_ph = M_RD_END;
                M_RD_END: if (!fs_rd) m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    // Handshake-side driver: per-cycle wr_valid / rd_ready / wr_data, optionally
    // from directed pattern queues that are consumed while the matching side works.
    bit       vpat [$];
    bit       rpat [$];
    bit [7:0] dpat [$];
    bit       rnd_valid = 1'b0, rnd_ready = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            wr_valid = (vpat.size() > 0) ? vpat[0] : (rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1);
            rd_ready = (rpat.size() > 0) ? rpat[0] : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            wr_data  = (dpat.size() > 0) ? dpat[0] : 8'($urandom);
            @(negedge clk);
            if (wr_ready && wr_valid && dpat.size() > 0) void'(dpat.pop_front());
            if (wr_ready && vpat.size() > 0) void'(vpat.pop_front());
            if (busy && !wr_ready && !fd_wr && !fd_rd && rpat.size() > 0) void'(rpat.pop_front());
        end
    end

    task automatic clear_logs();
        acc_addr.delete();
        acc_we.delete();
        acc_cyc.delete();
        rd_log.delete();
        rd_cyc.delete();
        fdrd_cyc.delete();
    endtask

    function automatic int acc_a(input int i);
        return (i < acc_addr.size()) ? acc_addr[i] : -1;
    endfunction

    function automatic int acc_w(input int i);
        return (i < acc_we.size()) ? int'(acc_we[i]) : -1;
    endfunction

    // Raise the requested sides, complete the handshake(s), and wait for IDLE.
    task automatic run(input bit do_wr, input bit do_rd, input int wb, input int wl,
                       input int rb, input int rl, input bit early);
        bit wdone, rdone, wseen, rseen;
        int t;
        @(posedge clk);
        #1;
        wr_addr_init = AW'(wb);
        wr_dlen = AW'(wl);
        rd_addr_init = AW'(rb);
        rd_dlen = AW'(rl);
        fs_wr = do_wr;
        fs_rd = do_rd;
        wdone = !do_wr;
        rdone = !do_rd;
        wseen = 1'b0;
        rseen = 1'b0;
        t = 0;
        while (!(wdone && rdone) && t < 500) begin
            @(negedge clk);
            t++;
            if (fd_wr) wdone = 1'b1;
            if (fd_rd) rdone = 1'b1;
            if (ram_en && ram_we) wseen = 1'b1;
            if (ram_en && !ram_we) rseen = 1'b1;
            @(posedge clk);
            #1;
            if (fs_wr && (wdone || (early && wseen))) fs_wr = 1'b0;
            if (fs_rd && (rdone || (early && rseen))) fs_rd = 1'b0;
        end
        check("burst_done_seen", wdone && rdone, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 20);
        check("back_to_idle", busy, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        fs_wr = 1'b0;
        fs_rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit dw, dr;
        int wb, rb;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_lit", busy, 0);
        check("reset_ram_en_lit", ram_en, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: write-only burst on consecutive cycles
        clear_logs();
        run(1, 0, 'h240, 3, 0, 0, 0);
        check("t1_count", acc_addr.size(), 3);
        check("t1_a0", acc_a(0), 'h240);
        check("t1_a1", acc_a(1), 'h241);
        check("t1_a2", acc_a(2), 'h242);
        check("t1_we", acc_w(0) + acc_w(1) + acc_w(2), 3);
        if (acc_cyc.size() == 3) check("t1_consecutive", acc_cyc[2] - acc_cyc[0], 2);

        // 2: preload A0/A1 at 0xFCC, then read them back
        dpat = '{8'hA0, 8'hA1};
        run(1, 0, 'hFCC, 2, 0, 0, 0);
        clear_logs();
        run(0, 1, 0, 0, 'hFCC, 2, 0);
        check("t2_rd_count", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("t2_d0", rd_log[0], 8'hA0);
            check("t2_d1", rd_log[1], 8'hA1);
            check("t2_back_to_back", rd_cyc[1] - rd_cyc[0], 1);
        end
        if (rd_cyc.size() == 2 && fdrd_cyc.size() > 0)
            check("t2_fd_after_drain", fdrd_cyc[0], rd_cyc[1] + 1);
        else
            check("t2_fd_seen", fdrd_cyc.size() > 0 && rd_cyc.size() == 2, 1);

        // 3: contention after reset goes to the writer; after a write grant, to the reader
        pulse_reset();
        clear_logs();
        run(1, 1, 'h100, 2, 'h100, 2, 0);
        check("t3_first_is_wr", acc_w(0), 1);
        check("t3_then_rd", acc_w(2), 0);
        run(1, 0, 'h300, 1, 0, 0, 0);
        clear_logs();
        run(1, 1, 'h310, 2, 'h310, 2, 0);
        check("t3_rr_first_is_rd", acc_w(0), 0);
        check("t3_rr_then_wr", acc_w(2), 1);

        // 4: backpressure on both sides
        vpat = '{1, 0, 1, 1, 0, 1};
        clear_logs();
        run(1, 0, 'h500, 4, 0, 0, 0);
        vpat.delete();
        check("t4_wr_count", acc_addr.size(), 4);
        for (int i = 0; i < 4; i++) check("t4_wr_addr", acc_a(i), 'h500 + i);
        if (acc_cyc.size() == 4) check("t4_wr_spacing", acc_cyc[3] - acc_cyc[0], 5);
        rpat = '{1, 0, 1, 0, 0, 1, 1};
        clear_logs();
        run(0, 1, 0, 0, 'h500, 4, 0);
        rpat.delete();
        check("t4_rd_count", acc_addr.size(), 4);
        for (int i = 0; i < 4; i++) check("t4_rd_addr", acc_a(i), 'h500 + i);
        check("t4_rd_words", rd_log.size(), 4);

        // 5: zero-length bursts and address wrap
        clear_logs();
        run(1, 0, 'h10, 0, 0, 0, 0);
        run(0, 1, 0, 0, 'h20, 0, 0);
        check("t5_zero_len_no_access", acc_addr.size(), 0);
        clear_logs();
        run(1, 0, 'hFFE, 4, 0, 0, 0);
        check("t5_wrap_0", acc_a(0), 'hFFE);
        check("t5_wrap_1", acc_a(1), 'hFFF);
        check("t5_wrap_2", acc_a(2), 'h000);
        check("t5_wrap_3", acc_a(3), 'h001);

        // 6: asynchronous reset in the middle of a write burst
        @(posedge clk);
        #1;
        wr_addr_init = 12'h600;
        wr_dlen = 12'd5;
        fs_wr = 1'b1;
        clear_logs();
        t = 0;
        while (acc_addr.size() < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t6_two_words_before_reset", acc_addr.size(), 2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_ram_en_cleared", ram_en, 0);
        check("t6_wr_ready_cleared", wr_ready, 0);
        check("t6_fd_wr_cleared", fd_wr, 0);
        check("t6_busy_cleared", busy, 0);
        fs_wr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        clear_logs();
        run(1, 0, 'h700, 2, 0, 0, 0);
        check("t6_after_reset_count", acc_addr.size(), 2);
        check("t6_after_reset_a0", acc_a(0), 'h700);
        check("t6_after_reset_a1", acc_a(1), 'h701);

        // Randomized bursts with throttling and occasional early fs drop
        rnd_valid = 1'b1;
        rnd_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            dw = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!dw && !dr) dw = 1'b1;
            wb = $urandom_range(0, 4095);
            rb = ($urandom_range(0, 1) == 1) ? wb : $urandom_range(0, 4095);
            run(dw, dr, wb, $urandom_range(0, 8), rb, $urandom_range(0, 8),
                $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
